// File: rtl/cache_mem_buffer_pkg.sv
// Shared definitions for the cache/memory block buffer: FSM state encoding,
// block-derived widths and small helpers.
// BW_BLOCK (log2 words per block) and BW_WORD_ADDR (word address width) may be
// supplied by the build; defaults give 16-word blocks and a 30-bit word address.
`ifndef BW_BLOCK
`define BW_BLOCK 4
`endif
`ifndef BW_WORD_ADDR
`define BW_WORD_ADDR 30
`endif

package cache_mem_buffer_pkg;

    localparam int unsigned BlockWordsMax = 2 ** `BW_BLOCK;
    // Length/count width: must represent a full block, hence one extra bit.
    localparam int unsigned LenW          = `BW_BLOCK + 1;
    localparam int unsigned AddrW         = `BW_WORD_ADDR;
    localparam int unsigned DataW         = 32;

    typedef enum logic [2:0] {
        StIdle,
        StWrFill,
        StWrMemReq,
        StWrMemData,
        StRdMemReq,
        StRdXfer
    } state_e;

    // Saturating increment for the performance counters.
    function automatic logic [DataW-1:0] sat_inc(input logic [DataW-1:0] v);
        return (v == '1) ? v : v + DataW'(1);
    endfunction

    // Block requests address the first word of their block.
    function automatic logic [AddrW-1:0] block_align(input logic [AddrW-1:0] a);
        return a & ~AddrW'(BlockWordsMax - 1);
    endfunction

endpackage

// File: rtl/block_word_fifo.sv
// Word FIFO holding one cache block between the cache and memory sides.
// Push and pop may occur in the same cycle; a push into a full FIFO is only
// accepted when a pop frees a slot in that cycle.
module block_word_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 32,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // Pointer and occupancy state; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage array; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/cache_mem_buffer.sv
// Block buffer between a cache and a burst memory port. A cache request
// (single word or whole block, read or write) is staged through a one-block
// FIFO: writes are filled from the cache then burst to memory; reads are
// requested from memory then drained by the cache.
// Optional feature: define CACHE_MEM_BUFFER_PERF_EN to enable saturating
// completed-transaction counters; otherwise the perf outputs are tied to 0.
`ifndef BW_BLOCK
`define BW_BLOCK 4
`endif
`ifndef BW_WORD_ADDR
`define BW_WORD_ADDR 30
`endif

module cache_mem_buffer
    import cache_mem_buffer_pkg::*;
#(
    // Must not exceed 2**BW_BLOCK so lengths fit mem_len_o.
    parameter int unsigned BLOCK_WORDS = BlockWordsMax,
    parameter bit          INIT_DONE   = 1'b1
) (
    input  logic                     clock_i,
    input  logic                     resetn_i,
    // Cache side
    input  logic                     req_i,
    input  logic                     req_block_i,
    input  logic                     rw_i,
    input  logic [`BW_WORD_ADDR-1:0] add_i,
    input  logic                     write_i,
    input  logic [31:0]              data_i,
    input  logic                     read_i,
    output logic                     ready_req_o,
    output logic                     ready_write_o,
    output logic                     ready_read_o,
    output logic [31:0]              data_o,
    // Memory side
    output logic                     mem_req_o,
    output logic                     mem_rw_o,
    output logic [`BW_WORD_ADDR-1:0] mem_add_o,
    output logic [`BW_BLOCK:0]       mem_len_o,
    output logic                     mem_wvalid_o,
    output logic [31:0]              mem_wdata_o,
    input  logic                     mem_ack_i,
    input  logic                     mem_wready_i,
    input  logic                     mem_rvalid_i,
    input  logic [31:0]              mem_rdata_i,
    // Performance counters
    output logic [31:0]              perf_rd_count_o,
    output logic [31:0]              perf_wr_count_o
);

    state_e            state_q;
    logic [LenW-1:0]   len_q;
    logic [LenW-1:0]   in_cnt_q;   // words pushed into the buffer this transaction
    logic [LenW-1:0]   out_cnt_q;  // words popped from the buffer this transaction
    logic              init_q;
    logic              mem_req_q;
    logic              mem_rw_q;
    logic [AddrW-1:0]  mem_add_q;

    logic [LenW-1:0]   fifo_count;
    logic [DataW-1:0]  fifo_rdata;
    logic [DataW-1:0]  fifo_wdata;
    logic              fifo_push, fifo_pop, buf_empty;
    logic              req_fire, wr_push, wr_pop, rd_push, rd_pop;
    logic              wr_done, rd_done;

    assign buf_empty = (fifo_count == '0);

    // Gated by resetn_i so every output reads 0 while reset is held.
    assign ready_req_o   = resetn_i && (state_q == StIdle) && (INIT_DONE || init_q);
    assign ready_write_o = (state_q == StWrFill) && (in_cnt_q < len_q);
    assign mem_wvalid_o  = (state_q == StWrMemData);
    assign ready_read_o  = (state_q == StRdXfer) && !buf_empty;

    assign mem_wdata_o = mem_wvalid_o ? fifo_rdata : '0;
    assign data_o      = ready_read_o ? fifo_rdata : '0;

    assign mem_req_o = mem_req_q;
    assign mem_rw_o  = mem_rw_q;
    assign mem_add_o = mem_add_q;
    assign mem_len_o = len_q;

    assign req_fire = req_i && ready_req_o;
    assign wr_push  = ready_write_o && write_i;
    assign wr_pop   = mem_wvalid_o && mem_wready_i;
    // Read data beyond the requested length is discarded.
    assign rd_push  = (state_q == StRdXfer) && mem_rvalid_i && (in_cnt_q < len_q);
    assign rd_pop   = ready_read_o && read_i;

    assign wr_done = wr_pop && (out_cnt_q == len_q - LenW'(1));
    assign rd_done = (state_q == StRdXfer)
                  && ((in_cnt_q + LenW'(rd_push)) == len_q)
                  && ((out_cnt_q + LenW'(rd_pop)) == len_q);

    assign fifo_push  = wr_push || rd_push;
    assign fifo_pop   = wr_pop || rd_pop;
    assign fifo_wdata = (state_q == StWrFill) ? data_i : mem_rdata_i;

    block_word_fifo #(
        .Depth (BLOCK_WORDS),
        .Width (DataW),
        .CntW  (LenW)
    ) u_fifo (
        .clk_i   (clock_i),
        .rst_ni  (resetn_i),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    // Transaction FSM with registered memory-request outputs.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= StIdle;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            init_q    <= 1'b0;
            mem_req_q <= 1'b0;
            mem_rw_q  <= 1'b0;
            mem_add_q <= '0;
        end else begin
            init_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (req_fire) begin
                        len_q     <= req_block_i ? LenW'(BLOCK_WORDS) : LenW'(1);
                        mem_add_q <= req_block_i ? block_align(add_i) : add_i;
                        mem_rw_q  <= rw_i;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        if (rw_i) begin
                            state_q <= StWrFill;
                        end else begin
                            state_q   <= StRdMemReq;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                StWrFill: begin
                    if (wr_push) begin
                        in_cnt_q <= in_cnt_q + LenW'(1);
                        if ((in_cnt_q + LenW'(1)) == len_q) begin
                            state_q   <= StWrMemReq;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                StWrMemReq: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= StWrMemData;
                    end
                end
                StWrMemData: begin
                    if (wr_pop) begin
                        out_cnt_q <= out_cnt_q + LenW'(1);
                    end
                    if (wr_done) begin
                        state_q <= StIdle;
                    end
                end
                StRdMemReq: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= StRdXfer;
                    end
                end
                StRdXfer: begin
                    if (rd_push) begin
                        in_cnt_q <= in_cnt_q + LenW'(1);
                    end
                    if (rd_pop) begin
                        out_cnt_q <= out_cnt_q + LenW'(1);
                    end
                    if (rd_done) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef CACHE_MEM_BUFFER_PERF_EN
    logic [31:0] perf_rd_q, perf_wr_q;

    // Count completed transactions, saturating at all-ones.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            perf_rd_q <= '0;
            perf_wr_q <= '0;
        end else begin
            if (rd_done) begin
                perf_rd_q <= sat_inc(perf_rd_q);
            end
            if (wr_done) begin
                perf_wr_q <= sat_inc(perf_wr_q);
            end
        end
    end

    assign perf_rd_count_o = perf_rd_q;
    assign perf_wr_count_o = perf_wr_q;
`else
    assign perf_rd_count_o = '0;
    assign perf_wr_count_o = '0;
`endif

endmodule

// File: tb/tb_cache_mem_buffer.sv
// Self-checking bench for cache_mem_buffer: directed scenarios plus randomized
// transactions, checked against a queue-based model of the buffer behaviour.
module tb_cache_mem_buffer;
    import cache_mem_buffer_pkg::*;

    localparam int unsigned BW = 16;

    logic              clock_i = 1'b0;
    logic              resetn_i = 1'b1;
    logic              req_i, req_block_i, rw_i, write_i, read_i;
    logic [AddrW-1:0]  add_i;
    logic [31:0]       data_i;
    logic              ready_req_o, ready_write_o, ready_read_o;
    logic [31:0]       data_o;
    logic              mem_req_o, mem_rw_o, mem_wvalid_o;
    logic [AddrW-1:0]  mem_add_o;
    logic [LenW-1:0]   mem_len_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_ack_i, mem_wready_i, mem_rvalid_i;
    logic [31:0]       mem_rdata_i;
    logic [31:0]       perf_rd_count_o, perf_wr_count_o;

    int checks = 0;
    int failures = 0;
    int exp_rd_done = 0;
    int exp_wr_done = 0;

    always #5 clock_i = ~clock_i;

    cache_mem_buffer #(
        .BLOCK_WORDS (BW),
        .INIT_DONE   (1'b1)
    ) dut (
        .clock_i         (clock_i),
        .resetn_i        (resetn_i),
        .req_i           (req_i),
        .req_block_i     (req_block_i),
        .rw_i            (rw_i),
        .add_i           (add_i),
        .write_i         (write_i),
        .data_i          (data_i),
        .read_i          (read_i),
        .ready_req_o     (ready_req_o),
        .ready_write_o   (ready_write_o),
        .ready_read_o    (ready_read_o),
        .data_o          (data_o),
        .mem_req_o       (mem_req_o),
        .mem_rw_o        (mem_rw_o),
        .mem_add_o       (mem_add_o),
        .mem_len_o       (mem_len_o),
        .mem_wvalid_o    (mem_wvalid_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_ack_i       (mem_ack_i),
        .mem_wready_i    (mem_wready_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .perf_rd_count_o (perf_rd_count_o),
        .perf_wr_count_o (perf_wr_count_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic perf_check(input string tag);
`ifdef CACHE_MEM_BUFFER_PERF_EN
        check(tag, {perf_rd_count_o, perf_wr_count_o}, {32'(exp_rd_done), 32'(exp_wr_done)});
`else
        check(tag, {perf_rd_count_o, perf_wr_count_o}, 64'd0);
`endif
    endtask

    // Memory request handshake: fields must hold until the ack, req drops after.
    task automatic mem_req_phase(input bit rw, input logic [AddrW-1:0] add, input int n,
                                 input int delay);
        logic [63:0] exp_f;
        exp_f = 64'({1'b1, rw, add, LenW'(n)});
        for (int d = 0; d <= delay; d++) begin
            check("mem_req_fields", 64'({mem_req_o, mem_rw_o, mem_add_o, mem_len_o}), exp_f);
            if (d == delay) mem_ack_i = 1'b1;
            @(negedge clock_i);
        end
        mem_ack_i = 1'b0;
        check("mem_req_drop", mem_req_o, 1'b0);
    endtask

    task automatic do_write(input logic [AddrW-1:0] addr, input bit block, input int delay,
                            input bit toggle, input bit seq_data, input int stop_at);
        logic [31:0]      q[$];
        logic [AddrW-1:0] exp_add;
        int               n, k, guard;
        n       = block ? BW : 1;
        exp_add = block ? (addr & ~AddrW'(BW - 1)) : addr;
        for (int i = 0; i < n; i++) q.push_back(seq_data ? 32'(i) : $urandom);
        check("wr_ready_req", ready_req_o, 1'b1);
        req_i = 1'b1; rw_i = 1'b1; req_block_i = block; add_i = addr;
        @(negedge clock_i);
        req_i = 1'b0; add_i = AddrW'($urandom);
        k = 0; guard = 0;
        while (k < n && guard < 200) begin
            check("fill_ready_write", ready_write_o, 1'b1);
            req_i = 1'($urandom_range(1));  // must be ignored while busy
            rw_i  = 1'b0;
            if ($urandom_range(3) != 0) begin
                write_i = 1'b1; data_i = q[k]; k++;
            end else begin
                write_i = 1'b0; data_i = $urandom;
            end
            @(negedge clock_i); guard++;
        end
        if (guard >= 200) check("fill_timeout", 1'b0, 1'b1);
        req_i = 1'b0;
        // Writes after the fill completes must be dropped.
        write_i = 1'b1; data_i = 32'hBAD0_BAD0;
        check("fill_done_ready_write", ready_write_o, 1'b0);
        mem_req_phase(1'b1, exp_add, n, delay);
        write_i = 1'b0;
        k = 0; guard = 0;
        while (k < n && guard < 400) begin
            if (k == stop_at) break;
            check("wr_wvalid", mem_wvalid_o, 1'b1);
            mem_wready_i = toggle ? 1'($urandom_range(1)) : 1'b1;
            if (mem_wready_i) begin
                check("wr_wdata", mem_wdata_o, q[k]);
                k++;
            end
            @(negedge clock_i); guard++;
        end
        mem_wready_i = 1'b0;
        if (guard >= 400) check("wdata_timeout", 1'b0, 1'b1);
        if (stop_at >= n) begin
            check("wr_done_idle", {mem_wvalid_o, ready_req_o}, 2'b01);
            exp_wr_done++;
        end
    endtask

    // mode 1 holds read_i and mem_rvalid_i high throughout the transfer.
    task automatic do_read(input logic [AddrW-1:0] addr, input bit block, input int delay,
                           input bit mode, input bit fixed_en, input logic [31:0] fixed_w);
        logic [31:0]      m[$];
        logic [AddrW-1:0] exp_add;
        int               n, sent, got, guard;
        bit               rv;
        n       = block ? BW : 1;
        exp_add = block ? (addr & ~AddrW'(BW - 1)) : addr;
        check("rd_ready_req", ready_req_o, 1'b1);
        req_i = 1'b1; rw_i = 1'b0; req_block_i = block; add_i = addr;
        @(negedge clock_i);
        req_i = 1'b0; add_i = AddrW'($urandom);
        mem_req_phase(1'b0, exp_add, n, delay);
        sent = 0; got = 0; guard = 0;
        while (got < n && guard < 400) begin
            check("rd_ready_read", ready_read_o, m.size() != 0);
            if (m.size() != 0) check("rd_data", data_o, m[0]);
            else check("rd_data_empty", data_o, 32'd0);
            req_i        = 1'($urandom_range(1));
            rw_i         = 1'b1;
            read_i       = mode ? 1'b1 : 1'($urandom_range(1));
            rv           = mode ? 1'b1 : 1'($urandom_range(1));
            mem_rvalid_i = rv;
            mem_rdata_i  = (fixed_en && sent == 0) ? fixed_w : $urandom;
            if (read_i && m.size() != 0) begin
                void'(m.pop_front());
                got++;
            end
            if (rv && sent < n) begin
                m.push_back(mem_rdata_i);
                sent++;
            end
            @(negedge clock_i); guard++;
        end
        req_i = 1'b0; read_i = 1'b0; mem_rvalid_i = 1'b0;
        if (guard >= 400) check("rd_timeout", 1'b0, 1'b1);
        check("rd_done_idle", {ready_read_o, ready_req_o}, 2'b01);
        exp_rd_done++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {ready_req_o, ready_write_o, ready_read_o, mem_req_o, mem_rw_o,
                               mem_wvalid_o}, 6'd0);
        check({tag, "_data"}, {data_o, mem_wdata_o}, 64'd0);
        check({tag, "_addlen"}, 64'({mem_add_o, mem_len_o}), 64'd0);
        check({tag, "_perf"}, {perf_rd_count_o, perf_wr_count_o}, 64'd0);
    endtask

    initial begin
        req_i = 0; req_block_i = 0; rw_i = 0; add_i = '0; write_i = 0; data_i = '0;
        read_i = 0; mem_ack_i = 0; mem_wready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        #1 resetn_i = 1'b0;
        #2 check_all_zero("reset");
        @(negedge clock_i); @(negedge clock_i);
        resetn_i = 1'b1;
        #1 check("init_ready_req", ready_req_o, 1'b1);
        @(negedge clock_i);

        // Block write of 0..15 at 0x1234 lands at 0x1230.
        do_write(AddrW'(32'h1234), 1'b1, 0, 1'b0, 1'b1, BW);
        // Single-word read of 0xDEADBEEF.
        do_read(AddrW'(32'h42), 1'b0, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        // Block read with read_i held: simultaneous push and pop.
        do_read(AddrW'($urandom), 1'b1, 1, 1'b1, 1'b0, 32'd0);
        // Slow ack and toggling wready.
        do_write(AddrW'($urandom), 1'b1, 10, 1'b1, 1'b0, BW);
        do_read(AddrW'($urandom), 1'b1, 10, 1'b0, 1'b0, 32'd0);
        for (int t = 0; t < 6; t++) begin
            if ($urandom_range(1) != 0)
                do_write(AddrW'($urandom), 1'($urandom_range(1)), int'($urandom_range(4)),
                         1'b1, 1'b0, BW);
            else
                do_read(AddrW'($urandom), 1'($urandom_range(1)), int'($urandom_range(4)),
                        1'($urandom_range(1)), 1'b0, 32'd0);
        end
        perf_check("perf_mid");

        // Abort a block write partway through its memory data phase.
        do_write(AddrW'($urandom), 1'b1, 2, 1'b1, 1'b0, 5);
        #2 resetn_i = 1'b0;
        #1 check_all_zero("abort");
        exp_rd_done = 0; exp_wr_done = 0;
        @(negedge clock_i);
        resetn_i = 1'b1;
        #1 check("abort_ready_req", ready_req_o, 1'b1);
        @(negedge clock_i);

        // Buffer must start empty: ready_read only follows fresh rvalid.
        do_read(AddrW'($urandom), 1'b0, 0, 1'b0, 1'b0, 32'd0);
        do_write(AddrW'($urandom), 1'b1, 3, 1'b1, 1'b0, BW);
        do_read(AddrW'($urandom), 1'b1, 0, 1'b1, 1'b0, 32'd0);
        do_read(AddrW'($urandom), 1'b1, 5, 1'b0, 1'b0, 32'd0);
        do_write(AddrW'($urandom), 1'b0, 1, 1'b0, 1'b0, BW);
        perf_check("perf_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
